alu_issue_ctrl: RTL and testbench

Multi-cycle issue/capture controller that sits in front of the 32-bit ALU (`alu32`). It accepts decoded operations over a valid/ready request port, translates ALUOp/funct into the 3-bit ALU control code and drives the operands. After a fixed settle interval it samples the result and Z/N/V flags and returns them over a valid/ready response port. It is the driving end of the ALU interface, so the datapath sees one registered, handshaked ALU transaction at a time.

---
 rtl/alu_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue/capture controller in front of alu32; one handshaked ALU transaction in flight.
// Latency: legal op rsp_valid rises SETTLE_CYCLES+2 edges after the accept edge; illegal op on the accept edge.
// Backpressure: req_ready only in IDLE; RESP holds all response outputs until rsp_ready.
//
// Ports:
//   clk, reset_n                          clock (rising) / async active-low reset
//   req_valid/req_ready                   request handshake; req_aluop, req_funct, req_a, req_b payload
//   alu_a, alu_b, alu_gin                 registered operands and 3-bit control code to the ALU
//   alu_sum, alu_zout, alu_n, alu_v       ALU result and flags
//   rsp_valid/rsp_ready                   response handshake; rsp_result, rsp_z/n/v, rsp_illegal payload
// Option macro: ALU_FLAG_RECOMPUTE_EN -- derive Z/N/V locally at capture and ignore the ALU flag inputs.

module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1   // legal range 1..15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_aluop,
   input  logic [5:0]  req_funct,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_gin,
   input  logic [31:0] alu_sum,
   input  logic        alu_zout,
   input  logic        alu_n,
   input  logic        alu_v,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_z,
   output logic        rsp_n,
   output logic        rsp_v,
   output logic        rsp_illegal
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_CAPTURE, S_RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   localparam logic [2:0] GIN_AND = 3'b000;
   localparam logic [2:0] GIN_OR  = 3'b001;
   localparam logic [2:0] GIN_ADD = 3'b010;
   localparam logic [2:0] GIN_SUB = 3'b110;
   localparam logic [2:0] GIN_SLT = 3'b111;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [2:0]  gin_q, gin_d;
   logic [31:0] result_q, result_d;
   logic        z_q, z_d, n_q, n_d, v_q, v_d, ill_q, ill_d;

   // Request decode: ALUOp/funct -> ALU control code
   logic [2:0] dec_gin;
   logic       dec_legal;

   always_comb begin
      dec_gin   = GIN_AND;
      dec_legal = 1'b1;
      case (req_aluop)
         2'b00: dec_gin = GIN_ADD;
         2'b01: dec_gin = GIN_SUB;
         2'b11: dec_gin = GIN_OR;
         default: begin
            case (req_funct)
               6'b100000: dec_gin = GIN_ADD;
               6'b100010: dec_gin = GIN_SUB;
               6'b100100: dec_gin = GIN_AND;
               6'b100101: dec_gin = GIN_OR;
               6'b101010: dec_gin = GIN_SLT;
               default:   dec_legal = 1'b0;
            endcase
         end
      endcase
   end

   // Flags sampled in CAPTURE
   logic cap_z, cap_n, cap_v;

`ifdef ALU_FLAG_RECOMPUTE_EN
   logic flags_unused;
   assign flags_unused = alu_zout ^ alu_n ^ alu_v;

   always_comb begin
      cap_z = (alu_sum == 32'd0);
      // slt produces 0/1, so its "sign" is the low bit
      cap_n = (gin_q == GIN_SLT) ? alu_sum[0] : alu_sum[31];
      cap_v = 1'b0;
      case (gin_q)
         GIN_ADD: cap_v = (alu_a_q[31] == alu_b_q[31]) && (alu_sum[31] != alu_a_q[31]);
         GIN_SUB: cap_v = (alu_a_q[31] != alu_b_q[31]) && (alu_sum[31] != alu_a_q[31]);
         default: cap_v = 1'b0;
      endcase
   end
`else
   assign cap_z = alu_zout;
   assign cap_n = alu_n;
   assign cap_v = alu_v;
`endif

   // Next-state / datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      gin_d    = gin_q;
      result_d = result_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      ill_d    = ill_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (dec_legal) begin
                  alu_a_d = req_a;
                  alu_b_d = req_b;
                  gin_d   = dec_gin;
                  ill_d   = 1'b0;
                  state_d = S_ISSUE;
               end else begin
                  // ALU inputs are left untouched by an illegal request
                  result_d = 32'd0;
                  z_d      = 1'b0;
                  n_d      = 1'b0;
                  v_d      = 1'b0;
                  ill_d    = 1'b1;
                  state_d  = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == 4'd0) state_d = S_CAPTURE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_CAPTURE: begin
            result_d = alu_sum;
            z_d      = cap_z;
            n_d      = cap_n;
            v_d      = cap_v;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         alu_a_q  <= 32'd0;
         alu_b_q  <= 32'd0;
         gin_q    <= 3'b000;
         result_q <= 32'd0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         gin_q    <= gin_d;
         result_q <= result_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         ill_q    <= ill_d;
      end
   end

   // Handshake outputs decode straight from the state register, so reset clears rsp_valid at once
   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_gin     = gin_q;
   assign rsp_result  = result_q;
   assign rsp_z       = z_q;
   assign rsp_n       = n_q;
   assign rsp_v       = v_q;
   assign rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: unit 0 uses the default settle interval, unit 1 uses SETTLE_CYCLES=4.
// Directed table vectors, hand-written multi-cycle sequences and random ops against a reference model.
// Each unit is driven by its own behavioural ALU.

module tb_alu_issue_ctrl;

   localparam int SC0 = 1;
   localparam int SC1 = 4;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req_aluop;
   logic [5:0]  req_funct;
   logic [31:0] req_a, req_b;

   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [31:0] alu_a       [2];
   logic [31:0] alu_b       [2];
   logic [2:0]  alu_gin     [2];
   logic [31:0] alu_sum     [2];
   logic        alu_zout    [2];
   logic        alu_n       [2];
   logic        alu_v       [2];
   logic        rsp_valid   [2];
   logic        rsp_ready   [2];
   logic [31:0] rsp_result  [2];
   logic        rsp_z       [2];
   logic        rsp_n       [2];
   logic        rsp_v       [2];
   logic        rsp_illegal [2];

   int checks   = 0;
   int failures = 0;

   logic [31:0] last_a   [2];
   logic [31:0] last_b   [2];
   logic [2:0]  last_gin [2];

   alu_issue_ctrl #(.SETTLE_CYCLES(SC0)) u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_gin(alu_gin[0]),
      .alu_sum(alu_sum[0]), .alu_zout(alu_zout[0]), .alu_n(alu_n[0]), .alu_v(alu_v[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .rsp_z(rsp_z[0]), .rsp_n(rsp_n[0]), .rsp_v(rsp_v[0]), .rsp_illegal(rsp_illegal[0])
   );

   alu_issue_ctrl #(.SETTLE_CYCLES(SC1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_gin(alu_gin[1]),
      .alu_sum(alu_sum[1]), .alu_zout(alu_zout[1]), .alu_n(alu_n[1]), .alu_v(alu_v[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .rsp_z(rsp_z[1]), .rsp_n(rsp_n[1]), .rsp_v(rsp_v[1]), .rsp_illegal(rsp_illegal[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu32 for each unit
   function automatic logic [31:0] alu_calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] g);
      case (g)
         3'b010:  return a + b;
         3'b110:  return a + ~b + 32'd1;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      for (int u = 0; u < 2; u++) begin
         alu_sum[u]  = alu_calc(alu_a[u], alu_b[u], alu_gin[u]);
         alu_zout[u] = (alu_sum[u] == 32'd0);
         alu_n[u]    = (alu_gin[u] == 3'b111) ? alu_sum[u][0] : alu_sum[u][31];
         alu_v[u]    = 1'b0;
         if (alu_gin[u] == 3'b010)
            alu_v[u] = (alu_a[u][31] == alu_b[u][31]) && (alu_sum[u][31] != alu_a[u][31]);
         else if (alu_gin[u] == 3'b110)
            alu_v[u] = (alu_a[u][31] != alu_b[u][31]) && (alu_sum[u][31] != alu_a[u][31]);
      end
   end

   // Reference model: operation chosen by name, results from signed integer arithmetic
   function automatic void ref_model(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b, input logic [2:0] prev_gin,
                                     output logic [31:0] res, output logic z, output logic n,
                                     output logic v, output logic ill, output logic [2:0] gin);
      string  kind;
      longint sa, sb, s;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      case (op)
         2'd0: kind = "add";
         2'd1: kind = "sub";
         2'd3: kind = "or";
         default: begin
            case (fn)
               6'd32:   kind = "add";
               6'd34:   kind = "sub";
               6'd36:   kind = "and";
               6'd37:   kind = "or";
               6'd42:   kind = "slt";
               default: kind = "ill";
            endcase
         end
      endcase
      res = 32'd0; v = 1'b0; ill = 1'b0; gin = prev_gin;
      if (kind == "add") begin
         s = sa + sb; res = s[31:0]; gin = 3'b010;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (kind == "sub") begin
         s = sa - sb; res = s[31:0]; gin = 3'b110;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (kind == "and") begin
         res = a & b; gin = 3'b000;
      end else if (kind == "or") begin
         res = a | b; gin = 3'b001;
      end else if (kind == "slt") begin
         res = (sa < sb) ? 32'd1 : 32'd0; gin = 3'b111;
      end else begin
         ill = 1'b1;
      end
      z = (res == 32'd0) && !ill;
      n = (kind == "slt") ? res[0] : res[31];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   // One transaction on unit u; hold = rsp_ready-low cycles after rsp_valid (0: ready already high)
   task automatic do_op(input int u, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic e_z, input logic e_n, input logic e_v,
                        input logic e_ill, input logic [2:0] e_gin, input int hold, input string tag);
      int k, w, lat;
      logic [31:0] ea, eb;
      lat = e_ill ? 0 : ((u == 0) ? SC0 : SC1) + 2;
      ea  = e_ill ? last_a[u] : a;
      eb  = e_ill ? last_b[u] : b;
      req_aluop = op; req_funct = fn; req_a = a; req_b = b;
      req_valid[u] = 1'b1;
      w = 0;
      while (!req_ready[u] && w < 50) begin @(posedge clk); #1; w++; end
      check({tag, ".req_ready"}, 32'(req_ready[u]), 32'd1);
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      if (hold == 0) rsp_ready[u] = 1'b1;
      k = 0;
      while (!rsp_valid[u] && k < 64) begin
         if (k == 1 && !e_ill) check({tag, ".gin_early"}, 32'(alu_gin[u]), 32'(e_gin));
         @(posedge clk); #1; k++;
      end
      check({tag, ".latency"}, 32'(k), 32'(lat));
      check({tag, ".result"},  rsp_result[u], e_res);
      check({tag, ".flags_zn_v_ill"}, {28'd0, rsp_z[u], rsp_n[u], rsp_v[u], rsp_illegal[u]},
            {28'd0, e_z, e_n, e_v, e_ill});
      check({tag, ".alu_gin"}, 32'(alu_gin[u]), 32'(e_gin));
      check({tag, ".alu_a"}, alu_a[u], ea);
      check({tag, ".alu_b"}, alu_b[u], eb);
      check({tag, ".busy_ready"}, 32'(req_ready[u]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 32'(rsp_valid[u]), 32'd1);
         check({tag, ".hold_result"}, rsp_result[u], e_res);
      end
      rsp_ready[u] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[u] = 1'b0;
      check({tag, ".post_valid"}, 32'(rsp_valid[u]), 32'd0);
      check({tag, ".post_ready"}, 32'(req_ready[u]), 32'd1);
      if (!e_ill) begin last_a[u] = a; last_b[u] = b; last_gin[u] = e_gin; end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a, b, res;
      logic        z, n, v, ill;
      logic [2:0]  gin;
      int          hold;
   } vec_t;

   vec_t tbl [12];

   initial begin
      automatic logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [31:0] m_res; logic m_z, m_n, m_v, m_ill; logic [2:0] m_gin;
      logic [1:0] r_op; logic [5:0] r_fn; logic [31:0] r_a, r_b;
      int k;

      tbl[0]  = '{2'b00, 6'h00, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 0};
      tbl[1]  = '{2'b01, 6'h00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1};
      tbl[2]  = '{2'b01, 6'h00, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 0};
      tbl[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFE, 32'd3, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 2};
      tbl[4]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 0};
      tbl[5]  = '{2'b10, 6'b000111, 32'h11111111, 32'h22222222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 0};
      tbl[6]  = '{2'b11, 6'h15, 32'h0000F0F0, 32'h0F0F0000, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1};
      tbl[7]  = '{2'b10, 6'b100000, 32'h80000000, 32'h80000000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 0};
      tbl[8]  = '{2'b10, 6'b100010, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 0};
      tbl[9]  = '{2'b10, 6'b100101, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3};
      tbl[10] = '{2'b10, 6'b100001, 32'hDEADBEEF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2};
      tbl[11] = '{2'b10, 6'b101010, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 0};

      reset_n = 1'b0;
      req_aluop = 2'b00; req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 1'b0; rsp_ready[u] = 1'b0;
         last_a[u] = 32'd0; last_b[u] = 32'd0; last_gin[u] = 3'b000;
      end
      #2;
      for (int u = 0; u < 2; u++) begin
         check("rst.req_ready", 32'(req_ready[u]), 32'd1);
         check("rst.rsp_valid", 32'(rsp_valid[u]), 32'd0);
         check("rst.alu_gin",   32'(alu_gin[u]), 32'd0);
         check("rst.alu_a",     alu_a[u], 32'd0);
         check("rst.rsp_result", rsp_result[u], 32'd0);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed table on the default-latency unit
      for (int i = 0; i < 12; i++)
         do_op(0, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].z, tbl[i].n,
               tbl[i].v, tbl[i].ill, tbl[i].gin, tbl[i].hold, $sformatf("vec%0d", i));

      // Random ops against the reference model, both units
      for (int i = 0; i < 60; i++) begin
         automatic int u = (i % 3 == 2) ? 1 : 0;
         r_op = 2'($urandom_range(0, 3));
         r_fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
         r_a  = (i % 5 == 0) ? {1'b1, 31'($urandom)} : $urandom;
         r_b  = (i % 7 == 0) ? r_a : $urandom;
         ref_model(r_op, r_fn, r_a, r_b, last_gin[u], m_res, m_z, m_n, m_v, m_ill, m_gin);
         do_op(u, r_op, r_fn, r_a, r_b, m_res, m_z, m_n, m_v, m_ill, m_gin,
               $urandom_range(0, 2), $sformatf("rnd%0d", i));
      end

      // SETTLE_CYCLES=4: stalled response, with a second request waiting on req_valid
      req_aluop = 2'b00; req_a = 32'd100; req_b = 32'd23; req_valid[1] = 1'b1;
      check("s4.ready0", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_aluop = 2'b01; req_a = 32'd50; req_b = 32'd8;
      k = 0;
      while (!rsp_valid[1] && k < 64) begin
         check("s4.busy_ready", 32'(req_ready[1]), 32'd0);
         @(posedge clk); #1; k++;
      end
      check("s4.latency", 32'(k), 32'd6);
      for (int i = 0; i < 5; i++) begin
         check("s4.hold_valid",  32'(rsp_valid[1]), 32'd1);
         check("s4.hold_result", rsp_result[1], 32'd123);
         check("s4.hold_alu_a",  alu_a[1], 32'd100);
         check("s4.hold_ready",  32'(req_ready[1]), 32'd0);
         @(posedge clk); #1;
      end
      check("s4.result_end", rsp_result[1], 32'd123);
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      check("s4.hs_valid", 32'(rsp_valid[1]), 32'd0);
      check("s4.hs_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      check("s4.accept2_ready", 32'(req_ready[1]), 32'd0);
      k = 0;
      while (!rsp_valid[1] && k < 64) begin @(posedge clk); #1; k++; end
      check("s4.latency2", 32'(k), 32'd6);
      check("s4.result2", rsp_result[1], 32'd42);
      check("s4.alu_a2", alu_a[1], 32'd50);
      check("s4.gin2", 32'(alu_gin[1]), 32'(3'b110));
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      check("s4.post2_valid", 32'(rsp_valid[1]), 32'd0);

      // Reset during SETTLE drops the op
      req_aluop = 2'b00; req_a = 32'd77; req_b = 32'd1; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rstmid.req_ready", 32'(req_ready[0]), 32'd1);
      check("rstmid.rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rstmid.alu_a",     alu_a[0], 32'd0);
      check("rstmid.alu_b",     alu_b[0], 32'd0);
      check("rstmid.alu_gin",   32'(alu_gin[0]), 32'd0);
      check("rstmid.rsp",       rsp_result[0], 32'd0);
      check("rstmid.flags", {28'd0, rsp_z[0], rsp_n[0], rsp_v[0], rsp_illegal[0]}, 32'd0);
      for (int u = 0; u < 2; u++) begin last_a[u] = 32'd0; last_b[u] = 32'd0; last_gin[u] = 3'b000; end
      @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("rstmid.no_rsp", 32'(rsp_valid[0]), 32'd0);
      end
      rsp_ready[0] = 1'b0;
      do_op(0, 2'b00, 6'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
